midpoint_line_drawer: RTL and testbench
=======================================

Name: midpoint_line_drawer

Overview:
Rasterizes one 2D line segment using integer midpoint (Bresenham) stepping. It emits one pixel write per step towards the frame buffer write port, which carries the DrawX/DrawY/draw_data path. It sits between the renderer control unit and the frame buffer, and is started and acknowledged through the draw_start/draw_done handshake. It covers all eight octants, clips off-screen pixels and honours frame-buffer backpressure.

Parameters:
H_RES, 640, horizontal resolution; pixels with x >= H_RES are clipped
V_RES, 480, vertical resolution; pixels with y >= V_RES are clipped
COORD_W, 10, width of every coordinate port

Ports:
Clk  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
draw_start  input  1  level request from control unit; sampled in IDLE
x0  input  COORD_W  start x, unsigned; latched on accept
y0  input  COORD_W  start y, unsigned; latched on accept
x1  input  COORD_W  end x, unsigned; latched on accept
y1  input  COORD_W  end y, unsigned; latched on accept
color  input  1  pixel value; latched on accept
fb_ready  input  1  frame buffer accepts the current write this cycle
draw_done  output  1  line complete; held until draw_start deasserts
draw_we  output  1  pixel write valid
DrawX  output  COORD_W  pixel x
DrawY  output  COORD_W  pixel y
draw_data  output  1  pixel value, equal to the latched color

Behaviour:
- Clock and reset: one clock (Clk). Reset is synchronous and active-high.
- Reset values: state IDLE; draw_done=0; draw_we=0; DrawX=0; DrawY=0; draw_data=0; all internal registers 0. Reset wins over every other input, including mid-line; no further writes are issued after it.
- IDLE: outputs idle. When draw_start=1, latch x0, y0, x1, y1 and color, then go to SETUP.
- SETUP (1 cycle), with all values signed and COORD_W+2 bits wide:
  - dx = |x1-x0|, dy = -|y1-y0|
  - sx = +1 if x0<x1, else -1; sy = +1 if y0<y1, else -1
  - err = dx+dy; current point (cx,cy) = (x0,y0)
  - Go to DRAW.
- DRAW:
  - Outputs: DrawX=cx, DrawY=cy, draw_data=color.
  - draw_we=1 if cx<H_RES and cy<V_RES, otherwise 0 (clipped).
  - A step completes when fb_ready=1 or the pixel is clipped. A clipped pixel never waits for fb_ready.
  - While the step is not complete, cx, cy, err and all outputs hold stable.
  - On step completion:
    - If (cx,cy)==(x1,y1), go to DONE.
    - Otherwise compute e2=2*err. If e2>=dy: err+=dy, cx+=sx. If e2<=dx: err+=dx, cy+=sy. Both updates may apply in the same cycle.
- DONE: draw_we=0 and draw_done=1. Stay until draw_start=0, then go to IDLE with draw_done=0. If draw_start is still high, no new line starts until it has been low for at least one cycle.
- Latency: draw_start is accepted at edge N. The first pixel is valid with draw_we=1 in cycle N+2. With fb_ready held at 1, the line emits exactly max(dx,-dy)+1 pixels, one per cycle, and draw_done rises one cycle after the last pixel.
- A degenerate line (start equals end) emits exactly one pixel.
- The endpoint is always reached; the step count never exceeds max(dx,-dy).
- draw_start is ignored in SETUP and DRAW. Endpoint inputs may change after acceptance without effect.

Test Plan:
- Horizontal (10,20)->(15,20), fb_ready=1, start at cycle 0 -> draw_we=1 in cycles 2..7 with DrawX=10..15, DrawY=20; draw_done=1 at cycle 8 and held until draw_start drops.
- Steep negative-x line (5,5)->(3,10) -> exactly 6 writes, in order: (5,5) (5,6) (4,7) (4,8) (3,9) (3,10).
- Single point (7,7)->(7,7), color=1 -> one write at (7,7) with draw_data=1, then draw_done.
- Backpressure on (0,0)->(3,3): hold fb_ready=0 for 3 cycles while (1,1) is presented -> DrawX=DrawY=1 and draw_we=1 stable for 4 cycles; no pixel skipped or duplicated; 4 writes total.
- Clipping (638,0)->(642,0) -> draw_we=1 only for x=638 and x=639; x=640..642 stepped with draw_we=0 regardless of fb_ready=0; draw_done follows.
- Reset asserted during the 3rd pixel of (0,0)->(100,0) -> next cycle: state IDLE, draw_we=0, draw_done=0, DrawX=0, DrawY=0. A fresh draw_start then draws the new line from its own x0.

Source files
------------

// File: rtl/midpoint_line_drawer.sv
// Midpoint (Bresenham) line rasterizer: one pixel write per step into the frame
// buffer, all eight octants, off-screen clipping and write backpressure.
module midpoint_line_drawer #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int COORD_W = 10
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               draw_start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic               color,
  input  logic               fb_ready,
  output logic               draw_done,
  output logic               draw_we,
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic               draw_data
);

  localparam int CW = COORD_W + 2;
  localparam logic [COORD_W:0] HLIM = (COORD_W+1)'(H_RES);
  localparam logic [COORD_W:0] VLIM = (COORD_W+1)'(V_RES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [COORD_W-1:0]        x0_q, y0_q, x1_q, y1_q;
  logic [COORD_W-1:0]        x0_d, y0_d, x1_d, y1_d;
  logic                      color_q, color_d;
  logic [COORD_W-1:0]        cx_q, cy_q, cx_d, cy_d;
  logic signed [CW-1:0]      err_q, err_d, dx_q, dx_d, dy_q, dy_d;
  logic                      sxn_q, sxn_d, syn_q, syn_d;

  logic signed [CW-1:0]      dx_raw, dy_raw, e2;
  logic                      clipped, step_x, step_y, at_end;

  always_comb begin
    dx_raw  = $signed({2'b00, x1_q}) - $signed({2'b00, x0_q});
    dy_raw  = $signed({2'b00, y1_q}) - $signed({2'b00, y0_q});
    // err stays within +/-(2^COORD_W - 1), so doubling fits in CW bits
    e2      = $signed({err_q[CW-2:0], 1'b0});
    step_x  = (e2 >= dy_q);
    step_y  = (e2 <= dx_q);
    clipped = !(({1'b0, cx_q} < HLIM) && ({1'b0, cy_q} < VLIM));
    at_end  = (cx_q == x1_q) && (cy_q == y1_q);

    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    color_d = color_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    err_d   = err_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    sxn_d   = sxn_q;
    syn_d   = syn_q;

    case (state_q)
      S_IDLE: begin
        if (draw_start) begin
          x0_d    = x0;
          y0_d    = y0;
          x1_d    = x1;
          y1_d    = y1;
          color_d = color;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        dx_d    = dx_raw[CW-1] ? -dx_raw : dx_raw;
        dy_d    = dy_raw[CW-1] ? dy_raw : -dy_raw;
        err_d   = (dx_raw[CW-1] ? -dx_raw : dx_raw) + (dy_raw[CW-1] ? dy_raw : -dy_raw);
        sxn_d   = !(x0_q < x1_q);
        syn_d   = !(y0_q < y1_q);
        cx_d    = x0_q;
        cy_d    = y0_q;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        // A clipped pixel advances without waiting on the frame buffer
        if (fb_ready || clipped) begin
          if (at_end) begin
            state_d = S_DONE;
          end else begin
            err_d = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
            if (step_x) cx_d = sxn_q ? cx_q - 1'b1 : cx_q + 1'b1;
            if (step_y) cy_d = syn_q ? cy_q - 1'b1 : cy_q + 1'b1;
          end
        end
      end
      default: begin
        if (!draw_start) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      err_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      sxn_q   <= 1'b0;
      syn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      color_q <= color_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      err_q   <= err_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      sxn_q   <= sxn_d;
      syn_q   <= syn_d;
    end
  end

  assign draw_we   = (state_q == S_DRAW) && !clipped;
  assign draw_done = (state_q == S_DONE);
  assign DrawX     = (state_q == S_DRAW) ? cx_q : '0;
  assign DrawY     = (state_q == S_DRAW) ? cy_q : '0;
  assign draw_data = (state_q == S_DRAW) ? color_q : 1'b0;

endmodule

// File: tb/tb_midpoint_line_drawer.sv
// Directed bench for midpoint_line_drawer: fixed lines with hand-computed pixels.
module tb_midpoint_line_drawer;

  logic       Clk = 1'b0;
  logic       Reset, draw_start, color, fb_ready;
  logic [9:0] x0, y0, x1, y1;
  logic       draw_done, draw_we, draw_data;
  logic [9:0] DrawX, DrawY;

  int checks = 0;
  int errors = 0;

  int wx[$], wy[$], wd[$];
  int tx[$], ty[$], twe[$];
  int ncyc;

  midpoint_line_drawer #(.H_RES(640), .V_RES(480), .COORD_W(10)) dut (
    .Clk(Clk), .Reset(Reset), .draw_start(draw_start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color), .fb_ready(fb_ready),
    .draw_done(draw_done), .draw_we(draw_we), .DrawX(DrawX), .DrawY(DrawY),
    .draw_data(draw_data)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Starts a line and samples every cycle until draw_done; fb_ready drops for
  // stall_len cycles while write number stall_idx is presented, and stays low
  // once ready_limit writes have been accepted.
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input logic col, input int stall_idx, input int stall_len,
                          input int ready_limit);
    int  stalled;
    bit  done_seen;
    bit  rdy;
    wx.delete(); wy.delete(); wd.delete();
    tx.delete(); ty.delete(); twe.delete();
    x0 = 10'(ax0); y0 = 10'(ay0); x1 = 10'(ax1); y1 = 10'(ay1);
    color = col; draw_start = 1'b1; fb_ready = 1'b1;
    tick();
    check("setup_we", draw_we, 0);
    x0 = 10'd999; y0 = 10'd999; x1 = 10'd1; y1 = 10'd1; color = ~col;
    stalled = 0; done_seen = 0; ncyc = 0;
    for (int c = 0; c < 300 && !done_seen; c++) begin
      tick();
      ncyc++;
      if (draw_done) begin
        done_seen = 1;
      end else begin
        tx.push_back(DrawX); ty.push_back(DrawY); twe.push_back(draw_we);
        rdy = (wx.size() < ready_limit);
        if (draw_we && wx.size() == stall_idx && stalled < stall_len) begin
          rdy = 0;
          stalled++;
        end
        fb_ready = rdy;
        if (draw_we && rdy) begin
          wx.push_back(DrawX); wy.push_back(DrawY); wd.push_back(draw_data);
        end
      end
    end
    if (!done_seen) check("done_timeout", 0, 1);
    fb_ready = 1'b1;
  endtask

  task automatic finish_line(input string tag);
    tick(); tick();
    check({tag, "_done_held"}, draw_done, 1);
    check({tag, "_done_we"}, draw_we, 0);
    draw_start = 1'b0;
    tick();
    check({tag, "_done_clr"}, draw_done, 0);
    tick();
  endtask

  initial begin
    int sx[6], sy[6];
    int stable;
    Reset = 1'b1; draw_start = 1'b0; color = 1'b0; fb_ready = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    tick(); tick();
    check("rst_we", draw_we, 0);
    check("rst_done", draw_done, 0);
    check("rst_x", DrawX, 0);
    check("rst_y", DrawY, 0);
    check("rst_data", draw_data, 0);
    Reset = 1'b0;
    tick();

    // Horizontal line
    run_line(10, 20, 15, 20, 1'b1, -1, 0, 1000);
    check("horiz_n", wx.size(), 6);
    check("horiz_cyc", ncyc, 7);
    for (int i = 0; i < wx.size() && i < 6; i++) begin
      check($sformatf("horiz_x%0d", i), wx[i], 10 + i);
      check($sformatf("horiz_y%0d", i), wy[i], 20);
      check($sformatf("horiz_d%0d", i), wd[i], 1);
    end
    finish_line("horiz");
    check("idle_we", draw_we, 0);

    // Steep line with negative x direction
    sx = '{5, 5, 4, 4, 3, 3};
    sy = '{5, 6, 7, 8, 9, 10};
    run_line(5, 5, 3, 10, 1'b0, -1, 0, 1000);
    check("steep_n", wx.size(), 6);
    check("steep_cyc", ncyc, 7);
    for (int i = 0; i < wx.size() && i < 6; i++) begin
      check($sformatf("steep_x%0d", i), wx[i], sx[i]);
      check($sformatf("steep_y%0d", i), wy[i], sy[i]);
      check($sformatf("steep_d%0d", i), wd[i], 0);
    end
    finish_line("steep");

    // Degenerate single point
    run_line(7, 7, 7, 7, 1'b1, -1, 0, 1000);
    check("point_n", wx.size(), 1);
    check("point_cyc", ncyc, 2);
    if (wx.size() > 0) begin
      check("point_x", wx[0], 7);
      check("point_y", wy[0], 7);
      check("point_d", wd[0], 1);
    end
    finish_line("point");

    // Backpressure on the diagonal, stalling while (1,1) is presented
    run_line(0, 0, 3, 3, 1'b1, 1, 3, 1000);
    check("bp_n", wx.size(), 4);
    check("bp_cyc", ncyc, 8);
    for (int i = 0; i < wx.size() && i < 4; i++) begin
      check($sformatf("bp_x%0d", i), wx[i], i);
      check($sformatf("bp_y%0d", i), wy[i], i);
    end
    stable = 0;
    for (int i = 0; i < tx.size(); i++)
      if (tx[i] == 1 && ty[i] == 1 && twe[i] == 1) stable++;
    check("bp_stable", stable, 4);
    finish_line("bp");

    // Clipping past the right edge, fb_ready low after two writes
    run_line(638, 0, 642, 0, 1'b1, -1, 0, 2);
    check("clip_n", wx.size(), 2);
    check("clip_cyc", ncyc, 6);
    check("clip_steps", tx.size(), 5);
    for (int i = 0; i < tx.size() && i < 5; i++) begin
      check($sformatf("clip_x%0d", i), tx[i], 638 + i);
      check($sformatf("clip_we%0d", i), twe[i], (i < 2) ? 1 : 0);
    end
    finish_line("clip");

    // Reset while the third pixel of a long line is presented
    x0 = 10'd0; y0 = 10'd0; x1 = 10'd100; y1 = 10'd0; color = 1'b1;
    draw_start = 1'b1; fb_ready = 1'b1;
    tick(); tick(); tick(); tick();
    check("mid_x", DrawX, 2);
    check("mid_we", draw_we, 1);
    Reset = 1'b1;
    tick();
    check("mrst_we", draw_we, 0);
    check("mrst_done", draw_done, 0);
    check("mrst_x", DrawX, 0);
    check("mrst_y", DrawY, 0);
    Reset = 1'b0; draw_start = 1'b0;
    tick(); tick();
    check("mrst_idle_we", draw_we, 0);
    run_line(50, 3, 52, 3, 1'b0, -1, 0, 1000);
    check("fresh_n", wx.size(), 3);
    if (wx.size() > 0) begin
      check("fresh_x0", wx[0], 50);
      check("fresh_y0", wy[0], 3);
    end
    finish_line("fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
